ppi_bus_sequencer: RTL and testbench
====================================

// Module: ppi_bus_sequencer
// PURPOSE
//  Shares the 8255-compatible PPI register interface between N_REQ requesters (CPU core,
//  debug/loader, DMA). Round-robin arbitrates, then sequences one bus cycle per grant:
//  setup (cs+a+din) -> strobe (rd or wr) -> hold -> ack. Captures read data from the PPI.
//  Sits between the requesters and the PPI's cs/rd/wr/a/din/dout pins.
// PARAMETERS
//  N_REQ       2  number of requesters (2..8)
//  SETUP_CYC   1  cycles cs/a/din valid before strobe (>=1)
//  STROBE_CYC  1  cycles rd or wr held high (>=1)
//  HOLD_CYC    1  cycles cs/a/din held after strobe drops (>=1)
// PORTS
//  clk        in   1          clock
//  reset      in   1          asynchronous reset, active-high
//  req        in   N_REQ      request per requester; held until ack
//  req_we     in   N_REQ      1 = write, 0 = read; valid while req
//  req_addr   in   2*N_REQ    register select per requester: [2i+1:2i]
//  req_wdata  in   8*N_REQ    write data per requester: [8i+7:8i]
//  ack        out  N_REQ      one-cycle completion pulse to the granted requester
//  rdata      out  8          read data from last completed read
//  busy       out  1          1 when not IDLE
//  ppi_cs     out  1          PPI chip select, active-high
//  ppi_rd     out  1          PPI read strobe, active-high
//  ppi_wr     out  1          PPI write strobe, active-high
//  ppi_a      out  2          PPI register address
//  ppi_din    out  8          data to PPI
//  ppi_dout   in   8          data from PPI (combinational on ppi_a)
// BEHAVIOUR
//  - Reset: state IDLE; ack, busy, ppi_cs/rd/wr = 0; ppi_a = 0; ppi_din = 0; rdata = 0;
//    round-robin pointer = 0. Reset mid-cycle aborts immediately; no ack issued.
//  - FSM: IDLE -> SETUP(SETUP_CYC) -> STROBE(STROBE_CYC) -> HOLD(HOLD_CYC) -> DONE(1) -> IDLE.
//    Single down-counter, width $clog2(max cycle param + 1), reloaded on each state entry.
//  - IDLE: if any req, grant the first asserted req at/after the pointer (wrapping);
//    latch we/addr/wdata and grant index into registers; pointer <= grant+1 mod N_REQ.
//  - SETUP/STROBE/HOLD: ppi_cs = 1, ppi_a/ppi_din = latched values (all registered outputs).
//    STROBE: ppi_wr = latched we, ppi_rd = !latched we. rd and wr never both high.
//  - Read: rdata <= ppi_dout on the last STROBE cycle; held until the next read completes.
//    Writes leave rdata unchanged.
//  - Write: wr high for STROBE_CYC cycles; PPI re-latches identical data each cycle (harmless,
//    incl. bit set/reset).
//  - DONE: ack[grant] = 1 for exactly one cycle; cs = 0. rdata valid in the ack cycle.
//  - Latency req->ack (defaults): 1+SETUP+STROBE+HOLD+1 = 5 cycles.
//  - Requester must drop req the cycle after ack unless issuing a new transaction; req held
//    -> treated as a new request, arbitrated normally.
//  - req dropped mid-transaction: transaction completes, ack still pulsed. Changes to
//    we/addr/wdata after grant are ignored.
//  - Minimum gap between PPI cycles: 1 (DONE) + 1 (IDLE) cycles with cs = 0.
// STRUCTURE
//  - ppi_pkg: state enum (IDLE, SETUP, STROBE, HOLD, DONE); address constants
//    PPI_PORT_A=2'b00, PPI_PORT_B=2'b01, PPI_PORT_C=2'b10, PPI_CTRL=2'b11; control-word
//    bit positions (CW_FLAG=7 .. CW_DIR_CL=0).
//  - Sub-module rr_arbiter (N parameter): req vector + pointer -> one-hot grant + index + valid.
// TESTING
//  - Reset then single write req[0], addr=0, wdata=8'h5A -> one wr pulse at a=0, din=5A;
//    ack[0] at cycle 5; cs low otherwise.
//  - Read req[1], addr=3, PPI idle after reset -> rdata=8'h9B, ack[1] at cycle 5, rd only.
//  - req=2'b11 held continuously -> grants alternate 0,1,0,1; no requester starved;
//    cs deasserts >=2 cycles between cycles.
//  - SETUP=2, STROBE=3, HOLD=2 -> cs high 7 cycles, wr high exactly cycles 3..5 of cs;
//    ack 9 cycles after req.
//  - Assert reset during STROBE -> cs/rd/wr/ack = 0 same cycle; no ack afterwards; next req
//    granted normally.
//  - Change req_wdata 8'h11->8'hEE after grant -> PPI sees 8'h11; req dropped mid-cycle ->
//    ack still pulses.

Source files
------------

// File: rtl/ppi_pkg.sv
// rtl/ppi_pkg.sv - shared types and constants for the PPI bus sequencer
//
// Purpose: bus-cycle state encoding, 8255 register addresses and control-word
// bit positions, plus a small constant helper used to size the cycle counter.
// Ports: none (package).

package ppi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } ppi_state_t;

    localparam logic [1:0] PPI_PORT_A = 2'b00;
    localparam logic [1:0] PPI_PORT_B = 2'b01;
    localparam logic [1:0] PPI_PORT_C = 2'b10;
    localparam logic [1:0] PPI_CTRL   = 2'b11;

    // 8255 control word: bit 7 set = mode definition, clear = port C bit set/reset
    localparam int CW_FLAG    = 7;
    localparam int CW_MODE_A1 = 6;
    localparam int CW_MODE_A0 = 5;
    localparam int CW_DIR_A   = 4;
    localparam int CW_DIR_CU  = 3;
    localparam int CW_MODE_B  = 2;
    localparam int CW_DIR_B   = 1;
    localparam int CW_DIR_CL  = 0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose: picks the first asserted request at or after i_ptr, wrapping at N.
// Ports:
//   i_req    [N-1:0]  request vector
//   i_ptr    [IW-1:0] highest-priority index this round
//   o_grant  [N-1:0]  one-hot grant (all zero when nothing requested)
//   o_idx    [IW-1:0] index of the granted request
//   o_valid           at least one request asserted

module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    always_comb begin : arb
        int k;
        k       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = int'(i_ptr) + i;
            if (k >= N) k = k - N;
            if (!o_valid && i_req[k]) begin
                o_valid    = 1'b1;
                o_idx      = IW'(k);
                o_grant[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ppi_bus_sequencer.sv
// rtl/ppi_bus_sequencer.sv - shares an 8255 PPI register port between requesters
//
// Purpose: round-robin arbitrates N_REQ requesters and runs one PPI bus cycle
// per grant: setup (cs+a+din) -> strobe (rd or wr) -> hold -> ack pulse.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req/req_we [N_REQ-1:0]     request and write-enable per requester
//   req_addr   [2*N_REQ-1:0]   register select, requester i at [2i+1:2i]
//   req_wdata  [8*N_REQ-1:0]   write data, requester i at [8i+7:8i]
//   ack        [N_REQ-1:0]     one-cycle completion pulse to the granted requester
//   rdata      [7:0]           data from the last completed read
//   busy                       sequencer not idle
//   ppi_cs/rd/wr/a/din         registered PPI pins
//   ppi_dout   [7:0]           PPI read data (combinational on ppi_a)

module ppi_bus_sequencer
    import ppi_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 1,
    parameter int HOLD_CYC   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     req_we,
    input  logic [2*N_REQ-1:0]   req_addr,
    input  logic [8*N_REQ-1:0]   req_wdata,
    output logic [N_REQ-1:0]     ack,
    output logic [7:0]           rdata,
    output logic                 busy,
    output logic                 ppi_cs,
    output logic                 ppi_rd,
    output logic                 ppi_wr,
    output logic [1:0]           ppi_a,
    output logic [7:0]           ppi_din,
    input  logic [7:0]           ppi_dout
);

    localparam int IW   = $clog2(N_REQ);
    localparam int MAXC = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
    localparam int CW   = $clog2(MAXC + 1);

    // counter holds "cycles remaining after this one" in each timed state
    localparam logic [CW-1:0] C_SETUP  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] C_STROBE = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] C_HOLD   = CW'(HOLD_CYC - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

    ppi_state_t         r_state;
    logic [CW-1:0]      r_cnt;
    logic [IW-1:0]      r_ptr;
    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   r_ack;
    logic               r_we;
    logic               r_cs;
    logic               r_rd;
    logic               r_wr;
    logic [1:0]         r_a;
    logic [7:0]         r_din;
    logic [7:0]         r_rdata;

    logic [N_REQ-1:0]   w_grant;
    logic [IW-1:0]      w_idx;
    logic               w_valid;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_grant <= '0;
            r_ack   <= '0;
            r_we    <= 1'b0;
            r_cs    <= 1'b0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_a     <= '0;
            r_din   <= '0;
            r_rdata <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        // request fields are frozen here; later changes are ignored
                        r_state <= ST_SETUP;
                        r_cnt   <= C_SETUP;
                        r_grant <= w_grant;
                        r_we    <= req_we[w_idx];
                        r_a     <= req_addr[2*int'(w_idx) +: 2];
                        r_din   <= req_wdata[8*int'(w_idx) +: 8];
                        r_ptr   <= (w_idx == LAST_IDX) ? '0 : w_idx + 1'b1;
                        r_cs    <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_STROBE;
                        r_cnt   <= C_STROBE;
                        r_rd    <= !r_we;
                        r_wr    <= r_we;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_STROBE: begin
                    if (r_cnt == '0) begin
                        // sample on the last strobe cycle so the PPI has had the full strobe
                        if (!r_we) r_rdata <= ppi_dout;
                        r_state <= ST_HOLD;
                        r_cnt   <= C_HOLD;
                        r_rd    <= 1'b0;
                        r_wr    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_DONE;
                        r_cs    <= 1'b0;
                        r_ack   <= r_grant;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cs    <= 1'b0;
                    r_rd    <= 1'b0;
                    r_wr    <= 1'b0;
                end
            endcase
        end
    end

    assign ack     = r_ack;
    assign rdata   = r_rdata;
    assign busy    = (r_state != ST_IDLE);
    assign ppi_cs  = r_cs;
    assign ppi_rd  = r_rd;
    assign ppi_wr  = r_wr;
    assign ppi_a   = r_a;
    assign ppi_din = r_din;

endmodule

// File: tb/tb_ppi_bus_sequencer.sv
// tb/tb_ppi_bus_sequencer.sv - self-checking bench for ppi_bus_sequencer

module tb_ppi_bus_sequencer;
    import ppi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b1;

    // default-timing instance
    logic [1:0]  req = '0, req_we = '0;
    logic [3:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  ack, ppi_a;
    logic [7:0]  rdata, ppi_din, ppi_dout;
    logic        busy, ppi_cs, ppi_rd, ppi_wr;

    // stretched-timing instance (SETUP=2, STROBE=3, HOLD=2)
    logic [1:0]  req2 = '0, req_we2 = '0;
    logic [3:0]  req_addr2 = '0;
    logic [15:0] req_wdata2 = '0;
    logic [1:0]  ack2, ppi_a2;
    logic [7:0]  rdata2, ppi_din2;
    logic [7:0]  ppi_dout2 = '0;
    logic        busy2, ppi_cs2, ppi_rd2, ppi_wr2;

    ppi_bus_sequencer dut (
        .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .busy(busy), .ppi_cs(ppi_cs),
        .ppi_rd(ppi_rd), .ppi_wr(ppi_wr), .ppi_a(ppi_a), .ppi_din(ppi_din), .ppi_dout(ppi_dout)
    );

    ppi_bus_sequencer #(.N_REQ(2), .SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) dut2 (
        .clk(clk), .reset(reset), .req(req2), .req_we(req_we2), .req_addr(req_addr2),
        .req_wdata(req_wdata2), .ack(ack2), .rdata(rdata2), .busy(busy2), .ppi_cs(ppi_cs2),
        .ppi_rd(ppi_rd2), .ppi_wr(ppi_wr2), .ppi_a(ppi_a2), .ppi_din(ppi_din2), .ppi_dout(ppi_dout2)
    );

    // behavioural 8255 register file: control writes with bit 7 clear do port C bit set/reset
    logic [7:0] ppi_reg [4] = '{8'h00, 8'h00, 8'h00, 8'h9B};
    assign ppi_dout = ppi_reg[ppi_a];
    always @(posedge clk) begin
        if (ppi_cs && ppi_wr) begin
            if (ppi_a == PPI_CTRL && !ppi_din[CW_FLAG])
                ppi_reg[PPI_PORT_C][ppi_din[3:1]] <= ppi_din[0];
            else
                ppi_reg[ppi_a] <= ppi_din;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // bus-level properties watched on every cycle
    logic prev_cs = 1'b0;
    int   gap = 100;
    always @(negedge clk) begin
        if (reset) begin
            gap = 100;
            prev_cs = 1'b0;
        end else begin
            if (ppi_rd || ppi_wr) chk("rd_wr_exclusive", int'(ppi_rd && ppi_wr), 0);
            if (ppi_cs && !prev_cs) chk("cs_gap_ge2", int'(gap >= 2), 1);
            gap = ppi_cs ? 0 : gap + 1;
            prev_cs = ppi_cs;
        end
    end

    // reference state: round-robin pointer, expected PPI contents, last read value
    int         exp_ptr = 0;
    logic [7:0] shadow [3];
    logic [7:0] last_rdata = '0;

    function automatic int winner(input logic [1:0] m);
        int w;
        w = -1;
        for (int k = 0; k < 2; k++)
            if (w < 0 && m[(exp_ptr + k) % 2]) w = (exp_ptr + k) % 2;
        return w;
    endfunction

    task automatic run_txn(input string tag, input logic [1:0] mask, input logic [1:0] we_v,
                           input logic [3:0] addr_v, input logic [15:0] data_v,
                           input logic [7:0] exp_rdata, input bit mid_change, input bit mid_drop);
        int w, cyc, cs_n, rd_n, wr_n, ack_cyc;
        logic [1:0] ack_v, s_a;
        logic [7:0] s_din, s_rd;
        bit got;
        w = winner(mask);
        cs_n = 0; rd_n = 0; wr_n = 0; ack_cyc = 0; got = 0;
        ack_v = '0; s_a = '0; s_din = '0; s_rd = '0;
        @(negedge clk);
        req_we = we_v; req_addr = addr_v; req_wdata = data_v; req = mask;
        cyc = 1;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (ppi_cs) cs_n++;
            if (ppi_rd || ppi_wr) begin s_a = ppi_a; s_din = ppi_din; end
            if (ppi_rd) rd_n++;
            if (ppi_wr) wr_n++;
            if (cyc == 2) begin
                if (mid_change) req_wdata[8*w +: 8] = 8'hEE;
                if (mid_drop) req[w] = 1'b0;
            end
            if (|ack) begin
                got = 1; ack_cyc = cyc; ack_v = ack; s_rd = rdata; req = '0;
            end
        end
        chk({tag, " ack_seen"}, int'(got), 1);
        chk({tag, " ack_cycle"}, ack_cyc, 5);
        chk({tag, " ack_onehot"}, int'(ack_v), 1 << w);
        chk({tag, " cs_cycles"}, cs_n, 3);
        chk({tag, " rd_cycles"}, rd_n, we_v[w] ? 0 : 1);
        chk({tag, " wr_cycles"}, wr_n, we_v[w] ? 1 : 0);
        chk({tag, " strobe_addr"}, int'(s_a), int'(addr_v[2*w +: 2]));
        chk({tag, " strobe_din"}, int'(s_din), int'(data_v[8*w +: 8]));
        chk({tag, " rdata"}, int'(s_rd), int'(exp_rdata));
        @(negedge clk);
        chk({tag, " ack_single_pulse"}, int'(ack), 0);
        chk({tag, " idle_after_done"}, int'(busy), 0);
        exp_ptr = (w + 1) % 2;
        last_rdata = exp_rdata;
    endtask

    task automatic run2(input string tag, input logic we, input logic [1:0] addr, input logic [7:0] data);
        int cyc, cs_n, rd_n, wr_n, wr_first, wr_last, ack_cyc;
        logic [7:0] last_dout, s_rd;
        bit got;
        cs_n = 0; rd_n = 0; wr_n = 0; wr_first = 0; wr_last = 0; ack_cyc = 0; got = 0;
        last_dout = '0; s_rd = '0;
        @(negedge clk);
        req_we2 = {2{we}}; req_addr2 = {2{addr}}; req_wdata2 = {2{data}}; req2 = 2'b01;
        cyc = 1;
        while (!got && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (ppi_cs2) begin
                cs_n++;
                if (ppi_wr2) begin
                    if (wr_first == 0) wr_first = cs_n;
                    wr_last = cs_n;
                    wr_n++;
                end
            end
            // a fresh value each strobe cycle shows which one gets captured
            if (ppi_rd2) begin
                rd_n++;
                ppi_dout2 = 8'h60 + 8'(rd_n);
                last_dout = ppi_dout2;
            end
            if (|ack2) begin
                got = 1; ack_cyc = cyc; s_rd = rdata2; req2 = '0;
            end
        end
        chk({tag, " ack_seen"}, int'(got), 1);
        chk({tag, " ack_cycle"}, ack_cyc, 9);
        chk({tag, " cs_cycles"}, cs_n, 7);
        if (we) begin
            chk({tag, " wr_cycles"}, wr_n, 3);
            chk({tag, " wr_first"}, wr_first, 3);
            chk({tag, " wr_last"}, wr_last, 5);
            chk({tag, " rd_cycles"}, rd_n, 0);
        end else begin
            chk({tag, " rd_cycles"}, rd_n, 3);
            chk({tag, " wr_cycles"}, wr_n, 0);
            chk({tag, " rdata_last_strobe"}, int'(s_rd), int'(last_dout));
        end
        @(negedge clk);
    endtask

    typedef struct {
        int         idx;
        logic       we;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t tbl [9];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [1:0]  m, wv;
        logic [3:0]  av;
        logic [15:0] dv;
        logic [7:0]  exp;
        int          w, n, cyc, expn, seen;

        tbl[0] = '{0, 1'b1, PPI_PORT_A, 8'h5A, 8'h00};
        tbl[1] = '{1, 1'b0, PPI_CTRL,   8'h00, 8'h9B};
        tbl[2] = '{0, 1'b0, PPI_PORT_A, 8'h00, 8'h5A};
        tbl[3] = '{1, 1'b1, PPI_PORT_B, 8'hC3, 8'h5A};
        tbl[4] = '{1, 1'b0, PPI_PORT_B, 8'h00, 8'hC3};
        tbl[5] = '{0, 1'b1, PPI_CTRL,   8'h05, 8'hC3};
        tbl[6] = '{0, 1'b0, PPI_PORT_C, 8'h00, 8'h04};
        tbl[7] = '{1, 1'b1, PPI_CTRL,   8'h0F, 8'h04};
        tbl[8] = '{1, 1'b0, PPI_PORT_C, 8'h00, 8'h84};

        repeat (3) @(negedge clk);
        chk("reset ack", int'(ack), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset cs", int'(ppi_cs), 0);
        chk("reset rd", int'(ppi_rd), 0);
        chk("reset wr", int'(ppi_wr), 0);
        chk("reset a", int'(ppi_a), 0);
        chk("reset din", int'(ppi_din), 0);
        chk("reset rdata", int'(rdata), 0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++)
            run_txn($sformatf("vec%0d", i), 2'b01 << tbl[i].idx, {2{tbl[i].we}},
                    {2{tbl[i].addr}}, {2{tbl[i].wdata}}, tbl[i].exp_rdata, 1'b0, 1'b0);

        shadow[0] = 8'h5A; shadow[1] = 8'hC3; shadow[2] = 8'h84;

        run_txn("wdata_change", 2'b01, 2'b11, 4'b0101, 16'h0011, last_rdata, 1'b1, 1'b0);
        shadow[1] = 8'h11;
        run_txn("req_drop", 2'b10, 2'b00, 4'b0101, 16'h0000, shadow[1], 1'b0, 1'b1);

        // both requesters held: grants must alternate
        @(negedge clk);
        req_we = 2'b00; req_addr = 4'b0000; req = 2'b11;
        expn = exp_ptr; n = 0; cyc = 0;
        while (n < 4 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (|ack) begin
                chk($sformatf("hold grant%0d", n), int'(ack), 1 << expn);
                chk($sformatf("hold rdata%0d", n), int'(rdata), int'(shadow[0]));
                expn = (expn + 1) % 2;
                n++;
                if (n == 4) req = '0;
            end
        end
        chk("hold ack_count", n, 4);
        exp_ptr = expn;
        last_rdata = shadow[0];
        @(negedge clk);

        for (int r = 0; r < 24; r++) begin
            m  = 2'($urandom_range(1, 3));
            wv = 2'($urandom);
            av = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
            dv = 16'($urandom);
            w  = winner(m);
            exp = wv[w] ? last_rdata : shadow[av[2*w +: 2]];
            run_txn($sformatf("rand%0d", r), m, wv, av, dv, exp, 1'b0, 1'b0);
            if (wv[w]) shadow[av[2*w +: 2]] = dv[8*w +: 8];
        end

        run2("long_wr", 1'b1, PPI_PORT_A, 8'hA5);
        run2("long_rd", 1'b0, PPI_PORT_B, 8'h00);

        // reset during STROBE aborts the cycle at once
        @(negedge clk);
        req_we = 2'b01; req_addr = 4'b0010; req_wdata = 16'h0077; req = 2'b01;
        cyc = 0;
        while (!ppi_wr && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort reached_strobe", int'(ppi_wr), 1);
        reset = 1'b1;
        #1;
        chk("abort cs", int'(ppi_cs), 0);
        chk("abort rd", int'(ppi_rd), 0);
        chk("abort wr", int'(ppi_wr), 0);
        chk("abort ack", int'(ack), 0);
        chk("abort busy", int'(busy), 0);
        req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (|ack) seen++;
        end
        chk("abort no_late_ack", seen, 0);
        chk("abort rdata_cleared", int'(rdata), 0);
        exp_ptr = 0;
        last_rdata = '0;
        run_txn("post_reset_wr", 2'b10, 2'b11, 4'b0000, 16'h3E3E, 8'h00, 1'b0, 1'b0);
        run_txn("post_reset_rd", 2'b01, 2'b00, 4'b0000, 16'h0000, 8'h3E, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
